// File: rtl/tri_draw_scheduler_pkg.sv
// Shared types and helpers for the triangle frame scheduler.
package tri_draw_scheduler_pkg;

  // Frame sequencing states.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLR_INIT = 3'd1,
    S_CLEAR    = 3'd2,
    S_FETCH    = 3'd3,
    S_START    = 3'd4,
    S_WAIT     = 3'd5,
    S_DONE     = 3'd6
  } sched_state_t;

  // A queued command carries three vertices (x and y each) plus a colour.
  localparam int VERTEX_FIELDS = 6;

  // Width of one packed command: {ax, ay, bx, by, cx, cy, colour}.
  function automatic int cmd_width(input int coord_w, input int colour_w);
    return VERTEX_FIELDS * coord_w + colour_w;
  endfunction

  // LSB offset of a vertex field; index 0 is cy, 5 is ax. Colour sits at bit 0.
  function automatic int vertex_lsb(input int idx, input int coord_w, input int colour_w);
    return colour_w + idx * coord_w;
  endfunction

  // The scheduler owns the pixel port only while clearing or drawing.
  function automatic logic drives_pixel_port(input sched_state_t s);
    return (s == S_CLEAR) || (s == S_WAIT);
  endfunction

endpackage

// File: rtl/tri_draw_scheduler_cmd_fifo.sv
// Synchronous command FIFO holding packed triangle commands.
module tri_cmd_fifo
  import tri_draw_scheduler_pkg::*;
#(
  parameter int WIDTH = 51,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Advance read/write pointers; reset empties the queue.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tri_draw_scheduler.sv
// Frame sequencer: clears the framebuffer, then feeds queued triangles to the
// draw engine, multiplexing the single VGA pixel-write port between the two.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for frame_start
// S_CLR_INIT | one cycle holding the grid counter in reset
// S_CLEAR    | sweeping the grid, plotting the latched clear colour
// S_FETCH    | pop next command, or finish the frame if queue is empty
// S_START    | one-cycle start pulse to the triangle engine
// S_WAIT     | engine owns the pixel port until tri_done
// S_DONE     | one-cycle frame_done pulse
module tri_draw_scheduler
  import tri_draw_scheduler_pkg::*;
#(
  parameter int COORD_W     = 8,
  parameter int COLOUR_W    = 3,
  parameter int DEPTH       = 8,
  parameter int CLEAR_X_MAX = 159,
  parameter int CLEAR_Y_MAX = 119
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [COORD_W-1:0]  cmd_ax,
  input  logic [COORD_W-1:0]  cmd_ay,
  input  logic [COORD_W-1:0]  cmd_bx,
  input  logic [COORD_W-1:0]  cmd_by,
  input  logic [COORD_W-1:0]  cmd_cx,
  input  logic [COORD_W-1:0]  cmd_cy,
  input  logic [COLOUR_W-1:0] cmd_colour,
  input  logic                frame_start,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                busy,
  output logic                frame_done,
  output logic [COORD_W-1:0]  tri_ax,
  output logic [COORD_W-1:0]  tri_ay,
  output logic [COORD_W-1:0]  tri_bx,
  output logic [COORD_W-1:0]  tri_by,
  output logic [COORD_W-1:0]  tri_cx,
  output logic [COORD_W-1:0]  tri_cy,
  output logic [COLOUR_W-1:0] tri_colour,
  output logic                tri_start,
  input  logic                tri_done,
  input  logic [COORD_W-1:0]  tri_px,
  input  logic [COORD_W-1:0]  tri_py,
  input  logic [COLOUR_W-1:0] tri_pcolour,
  input  logic                tri_plot,
  output logic                gc_resetn,
  output logic                gc_enable,
  output logic [COORD_W-1:0]  gc_x_max,
  output logic [COORD_W-1:0]  gc_y_max,
  input  logic [COORD_W-1:0]  gc_x,
  input  logic [COORD_W-1:0]  gc_y,
  input  logic                gc_eog,
  output logic [COORD_W-1:0]  oX,
  output logic [COORD_W-1:0]  oY,
  output logic [COLOUR_W-1:0] oColour,
  output logic                oPlot
);

  localparam int CMD_W  = cmd_width(COORD_W, COLOUR_W);
  localparam int OFF_CY = vertex_lsb(0, COORD_W, COLOUR_W);
  localparam int OFF_CX = vertex_lsb(1, COORD_W, COLOUR_W);
  localparam int OFF_BY = vertex_lsb(2, COORD_W, COLOUR_W);
  localparam int OFF_BX = vertex_lsb(3, COORD_W, COLOUR_W);
  localparam int OFF_AY = vertex_lsb(4, COORD_W, COLOUR_W);
  localparam int OFF_AX = vertex_lsb(5, COORD_W, COLOUR_W);

  sched_state_t        state;
  logic [COLOUR_W-1:0] clr_colour_q;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CMD_W-1:0]    fifo_din;
  logic [CMD_W-1:0]    fifo_dout;

  logic [COORD_W-1:0]  pix_x;
  logic [COORD_W-1:0]  pix_y;
  logic [COLOUR_W-1:0] pix_colour;
  logic                pix_plot;
  logic [COORD_W-1:0]  hold_x;
  logic [COORD_W-1:0]  hold_y;
  logic [COLOUR_W-1:0] hold_colour;

  assign gc_x_max = COORD_W'(CLEAR_X_MAX);
  assign gc_y_max = COORD_W'(CLEAR_Y_MAX);

  // Commands are accepted in every state; popping only happens in FETCH.
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state == S_FETCH) && !fifo_empty;
  assign fifo_din  = {cmd_ax, cmd_ay, cmd_bx, cmd_by, cmd_cx, cmd_cy, cmd_colour};

  tri_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Frame sequencer with registered control outputs and engine operands.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      tri_start    <= 1'b0;
      gc_resetn    <= 1'b0;
      gc_enable    <= 1'b0;
      clr_colour_q <= '0;
      tri_ax       <= '0;
      tri_ay       <= '0;
      tri_bx       <= '0;
      tri_by       <= '0;
      tri_cx       <= '0;
      tri_cy       <= '0;
      tri_colour   <= '0;
    end else begin
      frame_done <= 1'b0;
      tri_start  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            clr_colour_q <= clear_colour;
            busy         <= 1'b1;
            state        <= S_CLR_INIT;
          end
        end
        S_CLR_INIT: begin
          gc_resetn <= 1'b1;
          gc_enable <= 1'b1;
          state     <= S_CLEAR;
        end
        S_CLEAR: begin
          if (gc_eog) begin
            gc_resetn <= 1'b0;
            gc_enable <= 1'b0;
            state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (fifo_empty) begin
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else begin
            tri_ax     <= fifo_dout[OFF_AX +: COORD_W];
            tri_ay     <= fifo_dout[OFF_AY +: COORD_W];
            tri_bx     <= fifo_dout[OFF_BX +: COORD_W];
            tri_by     <= fifo_dout[OFF_BY +: COORD_W];
            tri_cx     <= fifo_dout[OFF_CX +: COORD_W];
            tri_cy     <= fifo_dout[OFF_CY +: COORD_W];
            tri_colour <= fifo_dout[COLOUR_W-1:0];
            tri_start  <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (tri_done) state <= S_FETCH;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Pixel port mux: clear sweep, engine pass-through, or idle with held coords.
  always_comb begin
    pix_x      = hold_x;
    pix_y      = hold_y;
    pix_colour = hold_colour;
    pix_plot   = 1'b0;
    if (state == S_CLEAR) begin
      pix_x      = gc_x;
      pix_y      = gc_y;
      pix_colour = clr_colour_q;
      pix_plot   = 1'b1;
    end else if (state == S_WAIT) begin
      pix_x      = tri_px;
      pix_y      = tri_py;
      pix_colour = tri_pcolour;
      pix_plot   = tri_plot;
    end
  end

  // Remember the last driven pixel so the port holds steady when not owned.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_x      <= '0;
      hold_y      <= '0;
      hold_colour <= '0;
    end else if (drives_pixel_port(state)) begin
      hold_x      <= pix_x;
      hold_y      <= pix_y;
      hold_colour <= pix_colour;
    end
  end

  assign oX      = pix_x;
  assign oY      = pix_y;
  assign oColour = pix_colour;
  assign oPlot   = pix_plot;

endmodule

// File: tb/tb_tri_draw_scheduler.sv
// Directed bench for tri_draw_scheduler with grid counter and engine models.
module tb_tri_draw_scheduler;

  localparam int CLR_PIX = 160 * 120;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_ax = '0, cmd_ay = '0, cmd_bx = '0, cmd_by = '0, cmd_cx = '0, cmd_cy = '0;
  logic [2:0] cmd_colour = '0;
  logic       frame_start = 1'b0;
  logic [2:0] clear_colour = '0;
  logic       busy, frame_done;
  logic [7:0] tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy;
  logic [2:0] tri_colour;
  logic       tri_start;
  logic       tri_done;
  logic [7:0] tri_px = '0, tri_py = '0;
  logic [2:0] tri_pcolour = '0;
  logic       tri_plot = 1'b0;
  logic       gc_resetn, gc_enable;
  logic [7:0] gc_x_max, gc_y_max;
  logic [7:0] gc_x, gc_y;
  logic       gc_eog;
  logic [7:0] oX, oY;
  logic [2:0] oColour;
  logic       oPlot;

  always #5 clock = ~clock;

  tri_draw_scheduler dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ax(cmd_ax), .cmd_ay(cmd_ay), .cmd_bx(cmd_bx), .cmd_by(cmd_by),
    .cmd_cx(cmd_cx), .cmd_cy(cmd_cy), .cmd_colour(cmd_colour),
    .frame_start(frame_start), .clear_colour(clear_colour),
    .busy(busy), .frame_done(frame_done),
    .tri_ax(tri_ax), .tri_ay(tri_ay), .tri_bx(tri_bx), .tri_by(tri_by),
    .tri_cx(tri_cx), .tri_cy(tri_cy), .tri_colour(tri_colour),
    .tri_start(tri_start), .tri_done(tri_done),
    .tri_px(tri_px), .tri_py(tri_py), .tri_pcolour(tri_pcolour), .tri_plot(tri_plot),
    .gc_resetn(gc_resetn), .gc_enable(gc_enable),
    .gc_x_max(gc_x_max), .gc_y_max(gc_y_max),
    .gc_x(gc_x), .gc_y(gc_y), .gc_eog(gc_eog),
    .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot)
  );

  // Grid counter model: x fastest, wraps at the maxima.
  always @(posedge clock) begin
    if (!gc_resetn) begin
      gc_x <= '0;
      gc_y <= '0;
    end else if (gc_enable) begin
      if (gc_x == gc_x_max) begin
        gc_x <= '0;
        gc_y <= (gc_y == gc_y_max) ? 8'd0 : gc_y + 8'd1;
      end else begin
        gc_x <= gc_x + 8'd1;
      end
    end
  end
  assign gc_eog = (gc_x == gc_x_max) && (gc_y == gc_y_max);

  // Engine model: tri_done pulses 10 cycles after each tri_start.
  int eng_cnt;
  always @(posedge clock) begin
    if (reset) begin
      eng_cnt  <= 0;
      tri_done <= 1'b0;
    end else begin
      tri_done <= 1'b0;
      if (tri_start) eng_cnt <= 9;
      else if (eng_cnt != 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) tri_done <= 1'b1;
      end
    end
  end

  // Monitor: expected raster scan of the clear, frame_done and tri_start log.
  logic        mon_arm = 1'b0, mon_arm_q = 1'b0;
  logic [2:0]  exp_col = '0;
  int          cyc = 0, plot_cnt = 0, scan_err = 0, extra_plot = 0;
  int          fd_cnt = 0, fd_cyc = 0, last_plot_cyc = 0, st_cnt = 0;
  logic [7:0]  ex = '0, ey = '0;
  logic [50:0] st_pk [16];
  int          st_cyc [16];

  always @(negedge clock) begin
    cyc++;
    if (mon_arm != mon_arm_q) begin
      mon_arm_q = mon_arm;
      plot_cnt = 0; scan_err = 0; extra_plot = 0; fd_cnt = 0; fd_cyc = 0;
      last_plot_cyc = 0; st_cnt = 0; ex = '0; ey = '0;
    end
    if (oPlot === 1'b1) begin
      if (plot_cnt < CLR_PIX) begin
        if (oX !== ex || oY !== ey || oColour !== exp_col) scan_err++;
        plot_cnt++;
        last_plot_cyc = cyc;
        if (ex == 8'd159) begin ex = '0; ey = ey + 8'd1; end
        else ex = ex + 8'd1;
      end else begin
        extra_plot++;
      end
    end
    if (frame_done === 1'b1) begin fd_cnt++; fd_cyc = cyc; end
    if (tri_start === 1'b1) begin
      if (st_cnt < 16) begin
        st_pk[st_cnt]  = {tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy, tri_colour};
        st_cyc[st_cnt] = cyc;
      end
      st_cnt++;
    end
  end

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_cmd(input logic [50:0] c);
    {cmd_ax, cmd_ay, cmd_bx, cmd_by, cmd_cx, cmd_cy, cmd_colour} = c;
  endtask

  task automatic wait_tri_start(input int budget, input string tag);
    int n = 0;
    while (tri_start !== 1'b1 && n < budget) begin step(); n++; end
    check(tag, tri_start, 1'b1);
  endtask

  task automatic wait_frame_done(input int budget, input string tag);
    int n = 0;
    while (frame_done !== 1'b1 && n < budget) begin step(); n++; end
    check(tag, frame_done, 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [50:0] cmds [9];
  logic [50:0] cmd_p;
  logic [50:0] tri_regs;

  initial begin
    cmds[0] = {8'd125, 8'd34, 8'd80, 8'd60, 8'd0, 8'd0, 3'b111};
    for (int i = 1; i < 9; i++)
      cmds[i] = {8'(i*16), 8'(i*16+1), 8'(i*16+2), 8'(i*16+3), 8'(i*16+4), 8'(i*16+5), 3'(i)};
    cmd_p = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 3'b010};

    // Reset state
    repeat (3) step();
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_tri_start", tri_start, 1'b0);
    check("rst_gc_enable", gc_enable, 1'b0);
    check("rst_gc_resetn", gc_resetn, 1'b0);
    check("rst_oplot", oPlot, 1'b0);
    check("rst_opix", {oX, oY, oColour}, 19'd0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    tri_regs = {tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy, tri_colour};
    check("rst_tri_regs", tri_regs, 51'd0);
    check("gc_max", {gc_x_max, gc_y_max}, {8'd159, 8'd119});
    reset = 1'b0;
    step();

    // Frame 1: clear colour 001, stray frame_start/tri_plot and a push during CLEAR
    exp_col = 3'b001; mon_arm = ~mon_arm;
    clear_colour = 3'b001; frame_start = 1'b1;
    step();
    frame_start = 1'b0; clear_colour = 3'b110;
    check("f1_busy_rise", busy, 1'b1);
    check("f1_clrinit_plot", oPlot, 1'b0);
    check("f1_clrinit_gcrst", gc_resetn, 1'b0);
    step();
    check("f1_first_plot", oPlot, 1'b1);
    check("f1_first_xy", {oX, oY}, 16'd0);
    check("f1_first_colour", oColour, 3'b001);
    check("f1_gc_ctrl", {gc_enable, gc_resetn}, 2'b11);
    frame_start = 1'b1;
    tri_plot = 1'b1; tri_px = 8'd7; tri_py = 8'd9; tri_pcolour = 3'b110;
    drive_cmd(cmd_p); cmd_valid = 1'b1;
    step();
    frame_start = 1'b0; cmd_valid = 1'b0;
    repeat (19000) step();
    tri_plot = 1'b0;
    wait_tri_start(400, "f1_start_timeout");
    tri_regs = {tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy, tri_colour};
    check("f1_tri_regs", tri_regs, cmd_p);
    step();
    tri_px = 8'd50; tri_py = 8'd40; tri_pcolour = 3'b100; tri_plot = 1'b1;
    #1;
    check("wait_pass_x", oX, 8'd50);
    check("wait_pass_y", oY, 8'd40);
    check("wait_pass_colour", oColour, 3'b100);
    check("wait_pass_plot", oPlot, 1'b1);
    step();
    tri_plot = 1'b0;
    #1;
    check("wait_no_plot", oPlot, 1'b0);
    wait_frame_done(50, "f1_done_timeout");
    step();
    check("f1_busy_fall", busy, 1'b0);
    check("f1_done_pulse", frame_done, 1'b0);
    check("f1_idle_plot", oPlot, 1'b0);
    check("f1_idle_hold", {oX, oY, oColour}, {8'd50, 8'd40, 3'b100});
    step();
    check("f1_fd_count", fd_cnt, 1);
    check("f1_plot_count", plot_cnt, CLR_PIX);
    check("f1_scan_err", scan_err, 0);
    check("f1_extra_plot", extra_plot, 1);
    check("f1_start_count", st_cnt, 1);
    check("f1_done_latency", fd_cyc - st_cyc[0], 12);

    // Frame 2: fill the FIFO, hold a 9th command until the first pop
    exp_col = 3'b010; mon_arm = ~mon_arm;
    for (int i = 0; i < 8; i++) begin
      drive_cmd(cmds[i]); cmd_valid = 1'b1;
      check($sformatf("fill_ready_%0d", i), cmd_ready, 1'b1);
      step();
    end
    drive_cmd(cmds[8]);
    check("full_ready", cmd_ready, 1'b0);
    repeat (3) step();
    check("full_hold", cmd_ready, 1'b0);
    clear_colour = 3'b010; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    repeat (100) step();
    check("full_in_clear", cmd_ready, 1'b0);
    wait_tri_start(19300, "f2_start_timeout");
    check("ready_after_pop", cmd_ready, 1'b1);
    step();
    check("ready_after_9th", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
    wait_frame_done(400, "f2_done_timeout");
    step();
    step();
    check("f2_fd_count", fd_cnt, 1);
    check("f2_start_count", st_cnt, 9);
    check("f2_plot_count", plot_cnt, CLR_PIX);
    check("f2_scan_err", scan_err, 0);
    check("f2_extra_plot", extra_plot, 0);
    for (int k = 0; k < 9; k++) check($sformatf("f2_tri_%0d", k), st_pk[k], cmds[k]);
    for (int k = 1; k < 9; k++) check($sformatf("f2_gap_%0d", k), st_cyc[k] - st_cyc[k-1], 12);
    check("f2_done_latency", fd_cyc - st_cyc[8], 12);

    // Frame 3: reset while the engine owns the port, with a command still queued
    exp_col = 3'b011; mon_arm = ~mon_arm;
    drive_cmd(cmds[1]); cmd_valid = 1'b1;
    step();
    drive_cmd(cmds[2]);
    step();
    cmd_valid = 1'b0;
    clear_colour = 3'b011; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_tri_start(19300, "f3_start_timeout");
    step();
    step();
    reset = 1'b1; tri_plot = 1'b1; tri_px = 8'd33; tri_py = 8'd44; tri_pcolour = 3'b101;
    step();
    check("rw_busy", busy, 1'b0);
    check("rw_cmd_ready", cmd_ready, 1'b1);
    check("rw_oplot", oPlot, 1'b0);
    check("rw_gc_resetn", gc_resetn, 1'b0);
    check("rw_gc_enable", gc_enable, 1'b0);
    check("rw_pulses", {tri_start, frame_done}, 2'b00);
    check("rw_opix", {oX, oY, oColour}, 19'd0);
    tri_regs = {tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy, tri_colour};
    check("rw_tri_regs", tri_regs, 51'd0);
    reset = 1'b0; tri_plot = 1'b0;
    step();
    check("rw_idle_busy", busy, 1'b0);

    // Frame 4: full clear after reset, nothing stale left to draw
    exp_col = 3'b101; mon_arm = ~mon_arm;
    step();
    clear_colour = 3'b101; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_frame_done(19400, "f4_done_timeout");
    step();
    check("f4_busy_fall", busy, 1'b0);
    step();
    check("f4_fd_count", fd_cnt, 1);
    check("f4_start_count", st_cnt, 0);
    check("f4_plot_count", plot_cnt, CLR_PIX);
    check("f4_scan_err", scan_err, 0);
    check("f4_extra_plot", extra_plot, 0);
    check("f4_done_latency", fd_cyc - last_plot_cyc, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tri_draw_scheduler.md
Name: tri_draw_scheduler

Overview:
- Frame-level sequencer for the triangle renderer.
- On each frame request, clears the framebuffer by sweeping the grid counter with a clear colour. It then feeds queued triangle commands one at a time to the draw_triangle engine.
- Owns the single VGA pixel-write port (x, y, colour, plot) and muxes it between the clear pass and the triangle engine.
- Sits between the command producer (CPU/test logic) and the draw_triangle + grid_counter + vga_adapter chain.

Parameters:
- COORD_W, 8, width of every x/y coordinate.
- COLOUR_W, 3, pixel colour width.
- DEPTH, 8, triangle command FIFO entries (power of two).
- CLEAR_X_MAX, 159, last x of clear sweep.
- CLEAR_Y_MAX, 119, last y of clear sweep.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  triangle command offered.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_ax, cmd_ay, cmd_bx, cmd_by, cmd_cx, cmd_cy  in  COORD_W each  vertices.
- cmd_colour  in  COLOUR_W  triangle colour.
- frame_start  in  1  pulse: begin clear+draw frame.
- clear_colour  in  COLOUR_W  sampled on accepted frame_start.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse at frame completion.
- tri_ax..tri_cy  out  COORD_W each  registered vertices to the engine.
- tri_colour  out  COLOUR_W  registered colour to the engine.
- tri_start  out  1  one-cycle start pulse to the engine.
- tri_done  in  1  one-cycle pulse from the engine when the triangle is finished.
- tri_px, tri_py  in  COORD_W  engine pixel coords.
- tri_pcolour  in  COLOUR_W  engine pixel colour.
- tri_plot  in  1  engine pixel strobe.
- gc_resetn  out  1  grid counter reset, active low.
- gc_enable  out  1  grid counter advance.
- gc_x_max, gc_y_max  out  COORD_W  tied to CLEAR_X_MAX / CLEAR_Y_MAX.
- gc_x, gc_y  in  COORD_W  grid counter position.
- gc_eog  in  1  high when gc_x==x_max and gc_y==y_max.
- oX, oY  out  COORD_W  pixel port to the VGA adapter.
- oColour  out  COLOUR_W  pixel port colour.
- oPlot  out  1  pixel port strobe.

Behaviour:
- Reset:
  - state=IDLE; FIFO emptied; busy=0, frame_done=0, tri_start=0, gc_enable=0, gc_resetn=0.
  - tri_* vertex/colour registers=0; oPlot=0, oX=oY=oColour=0.
  - Reset mid-frame aborts immediately. No pulse is emitted and the engine is not signalled; the engine shares the reset.
- FIFO:
  - Push on cmd_valid&&cmd_ready, accepted in any state.
  - Pop only in FETCH.
  - cmd_ready=0 when full. A push offered while full is dropped, and the producer must hold.
  - Simultaneous push+pop with non-full, non-empty FIFO: occupancy unchanged.
  - Push into an empty FIFO becomes visible to FETCH on the next cycle.
- States:
  - IDLE: frame_start → CLR_INIT and latch clear_colour. frame_start in any other state is ignored.
  - CLR_INIT (1 cycle): gc_resetn=0 → CLEAR.
  - CLEAR: gc_resetn=1, gc_enable=1.
    - oX=gc_x, oY=gc_y, oColour=latched clear colour, oPlot=1.
    - When gc_eog=1, the last pixel is plotted this cycle → FETCH.
    - Exactly (CLEAR_X_MAX+1)*(CLEAR_Y_MAX+1) plot cycles (19200 at defaults).
  - FETCH: FIFO empty → DONE; else pop head into tri_* registers → START.
  - START (1 cycle): tri_start=1 → WAIT.
  - WAIT: pixel port = tri_px/tri_py/tri_pcolour/tri_plot, passed through combinationally. tri_done → FETCH.
  - DONE (1 cycle): frame_done=1 → IDLE.
- Pixel port outside CLEAR/WAIT: oPlot=0; oX/oY/oColour hold the last value.
- tri_plot outside WAIT is ignored (not forwarded).
- tri_done outside WAIT is ignored.
- Commands pushed during CLEAR or WAIT are drawn in the current frame if present when FETCH is evaluated.
- Latency:
  - frame_start → first clear plot: 2 cycles.
  - tri_done → next tri_start: 2 cycles (FETCH, START).
  - Empty queue after clear → frame_done 2 cycles after the last clear plot.
- busy rises the cycle after frame_start is accepted and falls with the return to IDLE.

Decomposition:
- Shared header tri_sched_defs.vh:
  - state encodings: IDLE, CLR_INIT, CLEAR, FETCH, START, WAIT, DONE;
  - command packing width CMD_W = 6*COORD_W + COLOUR_W and field offsets.
- One sub-module: tri_cmd_fifo, a synchronous FIFO of width CMD_W and depth DEPTH with push/pop/full/empty and synchronous active-high reset.

Test Plan:
- Reset then frame_start, clear_colour=3'b001, empty FIFO:
  - 19200 oPlot cycles covering (0,0)…(159,119), all colour 001;
  - frame_done exactly once; busy low afterwards.
- Push 3 commands, e.g. (125,34),(80,60),(0,0) colour 111. frame_start with the engine model asserting tri_done 10 cycles after each tri_start:
  - three tri_start pulses, in FIFO order, with matching tri_* values;
  - frame_done after the third tri_done.
- Push 8 commands with no frame:
  - cmd_ready drops after the 8th;
  - a 9th held cmd_valid is accepted only after the first FETCH pop.
- During CLEAR: pulse frame_start (ignored, 19200 plots only) and push a command (drawn in this frame). Drive tri_plot high during CLEAR → oPlot shows only clear pixels.
- Assert reset during WAIT:
  - next cycle state IDLE, busy=0, cmd_ready=1, oPlot=0, gc_resetn=0;
  - subsequent frame_start runs a full clear with no stale commands.
- During WAIT, engine tri_plot with tri_px=50, tri_py=40, tri_pcolour=3'b100 → oX=50, oY=40, oColour=100, oPlot=1 in the same cycle.
